// File: rtl/adder_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : adder_subtractor
//  Brief    : Ripple-carry adder/subtractor with registered result and NZCV
//             flags. C=0 computes B + A, C=1 computes B - A by inverting A
//             and injecting C as the carry-in of bit 0.
//  Revision : 1.0  initial release
// ============================================================================
module adder_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    // Per-bit operand after the add/subtract mux, sum bits and carry chain.
    // w_carry[i] is the carry into bit i; w_carry[WIDTH] leaves the MSB.
    logic [WIDTH-1:0] w_a_mux;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;

    logic             w_negative;
    logic             w_zero;
    logic             w_carry_out;
    logic             w_overflow;

    logic [WIDTH-1:0] r_result;
    logic             r_negative;
    logic             r_zero;
    logic             r_carry_out;
    logic             r_overflow;

    // Subtraction is two's complement of A: invert it and add one via carry-in.
    assign w_carry[0] = C;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            // Mux selects A or ~A, then a full adder combines it with B.
            assign w_a_mux[i]   = C ? ~A[i] : A[i];
            assign w_sum[i]     = w_a_mux[i] ^ B[i] ^ w_carry[i];
            assign w_carry[i+1] = (w_a_mux[i] & B[i]) |
                                  (w_carry[i] & (w_a_mux[i] ^ B[i]));
        end
    endgenerate

    // Flags derive from the sum and the two carries around the MSB.
    assign w_negative  = w_sum[WIDTH-1];
    assign w_zero      = ~(|w_sum);
    assign w_carry_out = w_carry[WIDTH];
    assign w_overflow  = w_carry[WIDTH-1] ^ w_carry[WIDTH];

    // Output register: one-cycle latency, cleared asynchronously (Z set).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result    <= '0;
            r_negative  <= 1'b0;
            r_zero      <= 1'b1;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_result    <= w_sum;
            r_negative  <= w_negative;
            r_zero      <= w_zero;
            r_carry_out <= w_carry_out;
            r_overflow  <= w_overflow;
        end
    end

    assign result    = r_result;
    assign negative  = r_negative;
    assign zero      = r_zero;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_adder_subtractor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_adder_subtractor
//  Brief    : Scoreboard bench for adder_subtractor at WIDTH=1 and WIDTH=8.
//             Stimulus pushes hand-computed {result,N,Z,C,V} per operation;
//             a monitor pops and compares on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b1;

    logic [0:0] a1 = '0, b1 = '0;
    logic       c1 = 1'b0;
    logic [0:0] r1;
    logic       n1, z1, co1, v1;

    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0;
    logic [7:0] r8;
    logic       n8, z8, co8, v8;

    adder_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .A(a1), .B(b1), .C(c1),
        .result(r1), .negative(n1), .zero(z1), .carry_out(co1), .overflow(v1)
    );

    adder_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .A(a8), .B(b8), .C(c8),
        .result(r8), .negative(n8), .zero(z8), .carry_out(co8), .overflow(v8)
    );

    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];
    exp_t e1, e8;

    int errors = 0;
    int checks = 0;

    // Bench-side view of "an operation was captured last edge".
    logic drv1 = 1'b0, drv8 = 1'b0;
    logic pv1 = 1'b0, pv8 = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv1 <= 1'b0;
            pv8 <= 1'b0;
        end else begin
            pv1 <= drv1;
            pv8 <= drv8;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUTs present against the queue heads.
    always @(negedge clk) begin
        if (pv1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w1_unexpected: got output with empty queue, required queued entry");
            end else begin
                e1 = q1.pop_front();
                check(e1.name, {11'd0, r1, n1, z1, co1, v1}, e1.exp);
            end
        end
        if (pv8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w8_unexpected: got output with empty queue, required queued entry");
            end else begin
                e8 = q8.pop_front();
                check(e8.name, {4'd0, r8, n8, z8, co8, v8}, e8.exp);
            end
        end
    end

    // exp = {result, N, Z, C, V}
    task automatic op1(input logic a, input logic b, input logic c,
                       input logic [4:0] exp, input string name);
        exp_t t;
        @(posedge clk);
        #2;
        a1 = a; b1 = b; c1 = c; drv1 = 1'b1;
        t.exp = {11'd0, exp};
        t.name = name;
        q1.push_back(t);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] r, input logic [3:0] nzcv, input string name);
        exp_t t;
        @(posedge clk);
        #2;
        a8 = a; b8 = b; c8 = c; drv8 = 1'b1;
        t.exp = {4'd0, r, nzcv};
        t.name = name;
        q8.push_back(t);
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        drv1 = 1'b0;
        drv8 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q8.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (q1.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d entries left, required 0", q1.size(), q8.size());
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_w1"}, {11'd0, r1, n1, z1, co1, v1}, 16'h0004);
        check({tag, "_w8"}, {4'd0, r8, n8, z8, co8, v8}, 16'h0004);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        exp_t t;
        // Async reset before any clock edge.
        #1 reset_n = 1'b0;
        #1 check_reset("reset_async");
        // Reset holds through edges even with live inputs.
        a8 = 8'h7F; b8 = 8'h01; a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset("reset_hold");
        @(negedge clk);
        reset_n = 1'b1;

        // WIDTH=1 sweep of {A,B,C} = 0..7.
        op1(1'b0, 1'b0, 1'b0, 5'b00100, "w1_000");
        op1(1'b0, 1'b0, 1'b1, 5'b00110, "w1_001");
        op1(1'b0, 1'b1, 1'b0, 5'b11000, "w1_010");
        op1(1'b0, 1'b1, 1'b1, 5'b11010, "w1_011");
        op1(1'b1, 1'b0, 1'b0, 5'b11000, "w1_100");
        op1(1'b1, 1'b0, 1'b1, 5'b11001, "w1_101");
        op1(1'b1, 1'b1, 1'b0, 5'b00111, "w1_110");
        op1(1'b1, 1'b1, 1'b1, 5'b00110, "w1_111");
        idle();

        // WIDTH=8 directed vectors, mode toggling back to back.
        op8(8'h0F, 8'hF1, 1'b0, 8'h00, 4'b0110, "w8_add_zero");
        op8(8'h05, 8'h03, 1'b1, 8'hFE, 4'b1000, "w8_sub_borrow");
        op8(8'h01, 8'h7F, 1'b0, 8'h80, 4'b1001, "w8_add_ovf");
        op8(8'h01, 8'h80, 1'b1, 8'h7F, 4'b0011, "w8_sub_ovf");
        op8(8'h03, 8'h03, 1'b1, 8'h00, 4'b0110, "w8_sub_equal");
        op8(8'hFF, 8'hFF, 1'b0, 8'hFE, 4'b1010, "w8_add_neg1");
        op8(8'h80, 8'h00, 1'b1, 8'h80, 4'b1001, "w8_sub_min");
        op8(8'h80, 8'h80, 1'b0, 8'h00, 4'b0111, "w8_add_min");
        op8(8'h00, 8'h00, 1'b1, 8'h00, 4'b0110, "w8_sub_zero");
        op8(8'h12, 8'h34, 1'b0, 8'h46, 4'b0000, "w8_add_plain");
        idle();
        drain();

        // Mid-stream reset between edges with an uncaptured op on the inputs.
        @(posedge clk);
        #2;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b0;
        #1 reset_n = 1'b0;
        #1 check_reset("reset_mid");
        @(posedge clk);
        #1 check_reset("reset_mid_hold");

        // First edge after release captures this op with normal latency.
        @(negedge clk);
        a8 = 8'h22; b8 = 8'h11; c8 = 1'b1; drv8 = 1'b1;
        t.exp = {4'd0, 8'hEF, 4'b1000};
        t.name = "w8_after_reset";
        q8.push_back(t);
        #1 reset_n = 1'b1;
        op8(8'h01, 8'h01, 1'b0, 8'h02, 4'b0000, "w8_after_reset2");
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
